// File: rtl/ysyx_25010008_ifu.sv
// Instruction fetch unit: single-outstanding AXI4-Lite read master that hands
// each fetched word to decode and waits for the next PC from writeback.
//
// state    | meaning
// ST_AR    | address phase, arvalid high until arready
// ST_R     | data phase, rready high until rvalid
// ST_VALID | one-cycle ivalid pulse, inst ready for decode/commit
// ST_WAIT  | waiting for wb_valid with the next PC
// ST_ERR   | bus or alignment fault, terminal until reset
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic        ivalid,
  output logic [31:0] pc,
  input  logic        wb_valid,
  input  logic [31:0] dnpc,
  output logic        fault,
  output logic [31:0] inst_cnt
);

  localparam logic [2:0] ST_AR    = 3'd0;
  localparam logic [2:0] ST_R     = 3'd1;
  localparam logic [2:0] ST_VALID = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    inst_cnt_d = inst_cnt_q;
    case (state_q)
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) begin
          if (rresp == 2'b00) begin
            inst_d  = rdata;
            state_d = ST_VALID;
          end else begin
            fault_d = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_VALID, ST_WAIT: begin
        if (state_q == ST_VALID) inst_cnt_d = inst_cnt_q + 32'd1;
        // A same-cycle writeback in VALID skips WAIT entirely.
        if (wb_valid) begin
          pc_d = dnpc;
          if (dnpc[1:0] == 2'b00) begin
            state_d = ST_AR;
          end else begin
            fault_d = 1'b1;
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_AR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_AR;
      pc_q       <= RESET_PC;
      inst_q     <= NOP;
      fault_q    <= 1'b0;
      inst_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  // Handshake outputs are masked while reset is held so nothing leaks before release.
  assign arvalid  = (state_q == ST_AR)    & ~reset;
  assign rready   = (state_q == ST_R)     & ~reset;
  assign ivalid   = (state_q == ST_VALID) & ~reset;
  assign araddr   = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign fault    = fault_q;
  assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Directed plus randomized bench for the fetch unit; a transaction-level model
// tracks the expected pc, instruction, count and fault flag.
module tb_ysyx_25010008_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic        ivalid;
  logic [31:0] pc;
  logic        wb_valid;
  logic [31:0] dnpc;
  logic        fault;
  logic [31:0] inst_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_cnt;

  ysyx_25010008_ifu #(.RESET_PC(RESET_PC)) dut (
    .clock    (clock),
    .reset    (reset),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .inst     (inst),
    .ivalid   (ivalid),
    .pc       (pc),
    .wb_valid (wb_valid),
    .dnpc     (dnpc),
    .fault    (fault),
    .inst_cnt (inst_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rresp    = 2'b00;
    wb_valid = 1'b0;
    step();
    step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, NOP);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_ivalid", {31'd0, ivalid}, 32'd0);
    exp_pc   = RESET_PC;
    exp_inst = NOP;
    exp_cnt  = 32'd0;
    reset = 1'b0;
    #1;
    chk("rel_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rel_araddr", araddr, exp_pc);
  endtask

  // One read transaction from AR through the R beat; ends in the cycle after the beat.
  task automatic do_fetch(input int ar_delay, input int r_delay, input logic [31:0] word,
                          input logic [1:0] resp, input bit noise);
    chk("f_arvalid", {31'd0, arvalid}, 32'd1);
    chk("f_araddr", araddr, exp_pc);
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      if (noise) begin
        wb_valid = 1'($urandom);
        dnpc     = $urandom;
        rvalid   = 1'($urandom);
        rdata    = $urandom;
      end
      step();
      chk("ar_hold_arvalid", {31'd0, arvalid}, 32'd1);
      chk("ar_hold_araddr", araddr, exp_pc);
      chk("ar_hold_ivalid", {31'd0, ivalid}, 32'd0);
    end
    wb_valid = 1'b0;
    rvalid   = 1'b0;
    arready  = 1'b1;
    step();
    arready = 1'b0;
    chk("r_arvalid", {31'd0, arvalid}, 32'd0);
    chk("r_rready", {31'd0, rready}, 32'd1);
    for (int i = 0; i < r_delay; i++) begin
      if (noise) begin
        wb_valid = 1'($urandom);
        dnpc     = $urandom;
      end
      step();
      chk("r_wait_ivalid", {31'd0, ivalid}, 32'd0);
      chk("r_wait_rready", {31'd0, rready}, 32'd1);
      chk("r_wait_pc", pc, exp_pc);
    end
    wb_valid = 1'b0;
    rvalid   = 1'b1;
    rdata    = word;
    rresp    = resp;
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    if (resp == 2'b00) begin
      exp_inst = word;
      exp_cnt  = exp_cnt + 32'd1;
      chk("v_ivalid", {31'd0, ivalid}, 32'd1);
      chk("v_inst", inst, exp_inst);
      chk("v_rready", {31'd0, rready}, 32'd0);
    end else begin
      chk("e_fault", {31'd0, fault}, 32'd1);
      chk("e_ivalid", {31'd0, ivalid}, 32'd0);
      chk("e_inst", inst, exp_inst);
    end
  endtask

  // Called in the ivalid cycle; supplies the next PC after wb_delay cycles.
  task automatic do_next(input int wb_delay, input logic [31:0] npc, input bit noise);
    for (int i = 0; i < wb_delay; i++) begin
      if (noise) begin
        rvalid = 1'($urandom);
        rdata  = $urandom;
      end
      step();
      chk("w_ivalid", {31'd0, ivalid}, 32'd0);
      chk("w_arvalid", {31'd0, arvalid}, 32'd0);
      chk("w_inst", inst, exp_inst);
    end
    rvalid   = 1'b0;
    wb_valid = 1'b1;
    dnpc     = npc;
    step();
    wb_valid = 1'b0;
    exp_pc   = npc;
    chk("n_cnt", inst_cnt, exp_cnt);
    chk("n_pc", pc, exp_pc);
    if (npc[1:0] == 2'b00) begin
      chk("n_arvalid", {31'd0, arvalid}, 32'd1);
      chk("n_araddr", araddr, exp_pc);
      chk("n_fault", {31'd0, fault}, 32'd0);
    end else begin
      chk("n_fault", {31'd0, fault}, 32'd1);
      chk("n_arvalid", {31'd0, arvalid}, 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    arready  = 1'b0;
    rdata    = 32'd0;
    rresp    = 2'b00;
    rvalid   = 1'b0;
    wb_valid = 1'b0;
    dnpc     = 32'd0;
    exp_pc   = RESET_PC;
    exp_inst = NOP;
    exp_cnt  = 32'd0;

    // Basic fetch, same-cycle next PC
    do_reset();
    do_fetch(0, 0, 32'h0010_0093, 2'b00, 1'b0);
    do_next(0, 32'h8000_0004, 1'b0);
    chk("basic_cnt", inst_cnt, 32'd1);

    // Backpressure on both channels, delayed writeback
    do_fetch(3, 3, 32'hDEAD_BEEF, 2'b00, 1'b0);
    do_next(5, 32'h8000_0010, 1'b0);

    // Randomized fetch stream with stray handshakes in the ignoring states
    for (int n = 0; n < 30; n++) begin
      logic [31:0] rnd;
      rnd = $urandom;
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'b00, 1'b1);
      do_next($urandom_range(0, 4), {rnd[31:2], 2'b00}, 1'b1);
    end

    // Bus error response
    do_reset();
    do_fetch(0, 0, $urandom, 2'b10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1'($urandom);
      dnpc     = 32'h8000_0100;
      rvalid   = 1'($urandom);
      rdata    = $urandom;
      step();
      chk("err_arvalid", {31'd0, arvalid}, 32'd0);
      chk("err_rready", {31'd0, rready}, 32'd0);
      chk("err_ivalid", {31'd0, ivalid}, 32'd0);
      chk("err_pc", pc, RESET_PC);
      chk("err_inst", inst, NOP);
    end
    wb_valid = 1'b0;
    rvalid   = 1'b0;

    // Misaligned next PC
    do_reset();
    do_fetch(0, 0, 32'h0000_0517, 2'b00, 1'b0);
    do_next(0, 32'h8000_0006, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mis_pc", pc, 32'h8000_0006);
      chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
      chk("mis_fault", {31'd0, fault}, 32'd1);
    end

    // Reset while in R, then a stale rvalid right after release
    do_reset();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rr_rready", {31'd0, rready}, 32'd1);
    reset = 1'b1;
    step();
    chk("rr_pc", pc, RESET_PC);
    chk("rr_rready", {31'd0, rready}, 32'd0);
    reset  = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hBAD0_BAD0;
    step();
    rvalid = 1'b0;
    chk("rr_ivalid", {31'd0, ivalid}, 32'd0);
    chk("rr_inst", inst, NOP);
    chk("rr_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rr_araddr", araddr, RESET_PC);
    exp_pc   = RESET_PC;
    exp_inst = NOP;
    exp_cnt  = 32'd0;
    do_fetch(1, 0, 32'h0020_0113, 2'b00, 1'b0);
    do_next(0, 32'h8000_0004, 1'b0);

    // Counter wrap
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.inst_cnt_q;
    #1;
    chk("wrap_pre", inst_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    do_fetch(0, 1, 32'h0030_0193, 2'b00, 1'b0);
    do_next(1, 32'h8000_0008, 1'b0);
    chk("wrap_zero", inst_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
